// File: rtl/ac_motor_sequencer_if.sv
// rtl/ac_motor_sequencer_if.sv - control/status bundle between the host side and the motor sequencer
interface ac_motor_sequencer_if #(
    parameter int level_bits = 12
);
    logic                  RUN;
    logic                  DIR_REQ;
    logic [level_bits-1:0] TARGET;
    logic                  FAULT;
    logic                  ENABLE;
    logic                  CW;
    logic                  CCW;
    logic [level_bits-1:0] LEVEL;
    logic                  AT_LEVEL;
    logic [2:0]            STATE;

    modport master (
        output RUN, DIR_REQ, TARGET, FAULT,
        input  ENABLE, CW, CCW, LEVEL, AT_LEVEL, STATE
    );

    modport slave (
        input  RUN, DIR_REQ, TARGET, FAULT,
        output ENABLE, CW, CCW, LEVEL, AT_LEVEL, STATE
    );
endinterface

// File: rtl/ac_motor_sequencer.sv
// rtl/ac_motor_sequencer.sv - run/stop/direction sequencer with amplitude ramp, coast interlock and fault latch
module ac_motor_sequencer #(
    parameter int level_bits   = 12,
    parameter int ramp_div     = 1000,
    parameter int level_step   = 1,
    parameter int coast_cycles = 5000
) (
    input logic                 CLK,
    input logic                 RESET_N,
    ac_motor_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_RAMP_DOWN = 3'd2,
        S_COAST     = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam int                    pre_w      = $clog2(ramp_div + 1);
    localparam int                    cnt_w      = $clog2(coast_cycles + 1);
    localparam logic [level_bits:0]   step_x     = (level_bits + 1)'(level_step);
    localparam logic [level_bits-1:0] step_n     = level_bits'(level_step);
    localparam logic [pre_w-1:0]      pre_last   = pre_w'(ramp_div - 1);
    localparam logic [cnt_w-1:0]      coast_load = cnt_w'(coast_cycles);
    localparam logic [cnt_w-1:0]      cnt_one    = cnt_w'(1);

    state_t                state;
    logic [pre_w-1:0]      prescaler;
    logic [cnt_w-1:0]      coast_cnt;
    logic                  dir;
    logic [level_bits-1:0] level;
    logic                  enable, cw, ccw, at_level;

    logic                  tick;
    logic [level_bits:0]   level_x, target_x, up_sum, down_floor;
    logic [level_bits-1:0] track_next, decay_next;

    assign tick = (prescaler == pre_last);

    // One extra bit keeps the +step comparisons free of wrap near full scale.
    always_comb begin
        level_x    = {1'b0, level};
        target_x   = {1'b0, bus.TARGET};
        up_sum     = level_x + step_x;
        down_floor = target_x + step_x;
        track_next = level;
        if (level_x < target_x)
            track_next = (up_sum >= target_x) ? bus.TARGET : up_sum[level_bits-1:0];
        else if (level_x > target_x)
            track_next = (level_x <= down_floor) ? bus.TARGET : level - step_n;
        decay_next = (level_x > step_x) ? level - step_n : '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            prescaler <= '0;
            coast_cnt <= '0;
            dir       <= 1'b0;
            level     <= '0;
            enable    <= 1'b0;
            cw        <= 1'b0;
            ccw       <= 1'b0;
            at_level  <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (bus.FAULT) begin
                if (state != S_FAULT) prescaler <= '0;
                state    <= S_FAULT;
                level    <= '0;
                enable   <= 1'b0;
                cw       <= 1'b0;
                ccw      <= 1'b0;
                at_level <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.RUN) begin
                            state     <= S_RUN;
                            prescaler <= '0;
                            dir       <= bus.DIR_REQ;
                            enable    <= 1'b1;
                            cw        <= !bus.DIR_REQ;
                            ccw       <= bus.DIR_REQ;
                            level     <= '0;
                            at_level  <= (bus.TARGET == '0);
                        end
                    end
                    S_RUN: begin
                        if (!bus.RUN || bus.DIR_REQ != dir) begin
                            state     <= S_RAMP_DOWN;
                            prescaler <= '0;
                            at_level  <= 1'b0;
                        end else begin
                            if (tick) level <= track_next;
                            at_level <= ((tick ? track_next : level) == bus.TARGET);
                        end
                    end
                    S_RAMP_DOWN: begin
                        // The bridge stays driven until amplitude reaches zero, then coasts.
                        if (level == '0 || (tick && decay_next == '0)) begin
                            state     <= S_COAST;
                            prescaler <= '0;
                            coast_cnt <= coast_load;
                            level     <= '0;
                            enable    <= 1'b0;
                            cw        <= 1'b0;
                            ccw       <= 1'b0;
                        end else if (tick) begin
                            level <= decay_next;
                        end
                    end
                    S_COAST: begin
                        if (coast_cnt <= cnt_one) begin
                            prescaler <= '0;
                            if (bus.RUN) begin
                                state    <= S_RUN;
                                dir      <= bus.DIR_REQ;
                                enable   <= 1'b1;
                                cw       <= !bus.DIR_REQ;
                                ccw      <= bus.DIR_REQ;
                                at_level <= (bus.TARGET == '0);
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            coast_cnt <= coast_cnt - cnt_one;
                        end
                    end
                    S_FAULT: begin
                        if (!bus.RUN) begin
                            state     <= S_IDLE;
                            prescaler <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.STATE    = state;
    assign bus.LEVEL    = level;
    assign bus.ENABLE   = enable;
    assign bus.CW       = cw;
    assign bus.CCW      = ccw;
    assign bus.AT_LEVEL = at_level;
endmodule

// File: tb/tb_ac_motor_sequencer.sv
// tb/tb_ac_motor_sequencer.sv - vector table, corner sequences and randomized model check for ac_motor_sequencer
module tb_ac_motor_sequencer;
    localparam int LB    = 12;
    localparam int RD    = 4;
    localparam int STEP  = 100;
    localparam int COAST = 8;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ac_motor_sequencer_if #(.level_bits(LB)) bus ();

    ac_motor_sequencer #(
        .level_bits(LB), .ramp_div(RD), .level_step(STEP), .coast_cycles(COAST)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int n; bit run; bit dir; bit fault; int target;
        int st; int lvl; bit en; bit cw; bit ccw; bit at;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int n, input bit run, dir, fault, input int target,
                       input int st, lvl, input bit en, cw, ccw, at);
        vec_t v;
        v.n = n; v.run = run; v.dir = dir; v.fault = fault; v.target = target;
        v.st = st; v.lvl = lvl; v.en = en; v.cw = cw; v.ccw = ccw; v.at = at;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int st, lvl, input bit en, cw, ccw, at);
        n_cmp++;
        if (bus.STATE !== 3'(st) || bus.LEVEL !== 12'(lvl) || bus.ENABLE !== en ||
            bus.CW !== cw || bus.CCW !== ccw || bus.AT_LEVEL !== at) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d lvl=%0d en=%0b cw=%0b ccw=%0b at=%0b, want st=%0d lvl=%0d en=%0b cw=%0b ccw=%0b at=%0b",
                     name, $time, bus.STATE, bus.LEVEL, bus.ENABLE, bus.CW, bus.CCW, bus.AT_LEVEL,
                     st, lvl, en, cw, ccw, at);
        end
    endtask

    task automatic apply(input bit run, dir, fault, input int target);
        @(negedge CLK);
        bus.RUN = run; bus.DIR_REQ = dir; bus.FAULT = fault; bus.TARGET = 12'(target);
    endtask

    // Reference model: mode number, cycles since entering it, amplitude as plain ints.
    int m_state, m_level, m_age;
    bit m_dir, m_at;

    task automatic model_reset();
        m_state = 0; m_level = 0; m_age = 0; m_dir = 0; m_at = 0;
    endtask

    task automatic model_step(input bit run, dir_req, fault, input int target);
        int  nxt;
        bit  tick;
        nxt  = m_state;
        tick = (m_age % RD) == RD - 1;
        if (fault) begin
            nxt = 4; m_level = 0;
        end else begin
            case (m_state)
                0: if (run) begin nxt = 1; m_dir = dir_req; m_level = 0; end
                1: begin
                    if (!run || dir_req != m_dir) nxt = 2;
                    else if (tick) begin
                        if (m_level < target) m_level = (m_level + STEP > target) ? target : m_level + STEP;
                        else m_level = (m_level - STEP < target) ? target : m_level - STEP;
                    end
                end
                2: begin
                    if (m_level == 0) nxt = 3;
                    else if (tick) begin
                        m_level = (m_level - STEP < 0) ? 0 : m_level - STEP;
                        if (m_level == 0) nxt = 3;
                    end
                end
                3: if (m_age == COAST - 1) begin
                    nxt = run ? 1 : 0;
                    if (run) m_dir = dir_req;
                end
                default: if (!run) nxt = 0;
            endcase
        end
        m_at    = (nxt == 1) && (m_level == target);
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
    endtask

    task automatic check_model(input string name);
        bit en;
        en = (m_state == 1) || (m_state == 2);
        check(name, m_state, m_level, en, en && !m_dir, en && m_dir, m_at);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RUN = 0; bus.DIR_REQ = 0; bus.FAULT = 0; bus.TARGET = '0;
        RESET_N = 0;
        repeat (2) @(posedge CLK);
        #1 check("reset", 0, 0, 0, 0, 0, 0);

        // start, reversal
        add(1,   1, 0, 0, 250,  1, 0,    1, 1, 0, 0);
        add(3,   1, 0, 0, 250,  1, 0,    1, 1, 0, 0);
        add(1,   1, 0, 0, 250,  1, 100,  1, 1, 0, 0);
        add(4,   1, 0, 0, 250,  1, 200,  1, 1, 0, 0);
        add(3,   1, 0, 0, 250,  1, 200,  1, 1, 0, 0);
        add(1,   1, 0, 0, 250,  1, 250,  1, 1, 0, 1);
        add(1,   1, 1, 0, 250,  2, 250,  1, 1, 0, 0);
        add(4,   1, 1, 0, 250,  2, 150,  1, 1, 0, 0);
        add(4,   1, 1, 0, 250,  2, 50,   1, 1, 0, 0);
        add(3,   1, 1, 0, 250,  2, 50,   1, 1, 0, 0);
        add(1,   1, 1, 0, 250,  3, 0,    0, 0, 0, 0);
        add(7,   1, 1, 0, 250,  3, 0,    0, 0, 0, 0);
        add(1,   1, 1, 0, 250,  1, 0,    1, 0, 1, 0);
        add(12,  1, 1, 0, 250,  1, 250,  1, 0, 1, 1);
        // stop, with direction toggles ignored during ramp-down
        add(1,   0, 1, 0, 250,  2, 250,  1, 0, 1, 0);
        add(2,   0, 0, 0, 250,  2, 250,  1, 0, 1, 0);
        add(2,   0, 1, 0, 250,  2, 150,  1, 0, 1, 0);
        add(8,   0, 0, 0, 250,  3, 0,    0, 0, 0, 0);
        add(7,   0, 0, 0, 250,  3, 0,    0, 0, 0, 0);
        add(1,   0, 0, 0, 250,  0, 0,    0, 0, 0, 0);
        // saturation and tracking down
        add(1,   1, 0, 0, 4095, 1, 0,    1, 1, 0, 0);
        add(160, 1, 0, 0, 4095, 1, 4000, 1, 1, 0, 0);
        add(4,   1, 0, 0, 4095, 1, 4095, 1, 1, 0, 1);
        add(1,   1, 0, 0, 3900, 1, 4095, 1, 1, 0, 0);
        add(3,   1, 0, 0, 3900, 1, 3995, 1, 1, 0, 0);
        add(4,   1, 0, 0, 3900, 1, 3900, 1, 1, 0, 1);
        // fault latch and re-arm
        add(148, 1, 0, 0, 200,  1, 200,  1, 1, 0, 1);
        add(1,   1, 0, 1, 200,  4, 0,    0, 0, 0, 0);
        add(3,   1, 0, 0, 200,  4, 0,    0, 0, 0, 0);
        add(1,   0, 0, 0, 200,  0, 0,    0, 0, 0, 0);

        @(negedge CLK);
        RESET_N = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].run, vecs[i].dir, vecs[i].fault, vecs[i].target);
            repeat (vecs[i].n) @(posedge CLK);
            #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].en,
                     vecs[i].cw, vecs[i].ccw, vecs[i].at);
        end

        // ramp-down entered at zero amplitude goes straight to coast
        apply(1, 0, 0, 250);
        @(posedge CLK); #1 check("zero_run", 1, 0, 1, 1, 0, 0);
        apply(0, 0, 0, 250);
        @(posedge CLK); #1 check("zero_rd", 2, 0, 1, 1, 0, 0);
        @(posedge CLK); #1 check("zero_coast", 3, 0, 0, 0, 0, 0);
        repeat (8) @(posedge CLK);
        #1 check("zero_idle", 0, 0, 0, 0, 0, 0);

        // asynchronous reset between edges during ramp-down
        apply(1, 0, 0, 250);
        repeat (13) @(posedge CLK);
        #1 check("rst_pre_run", 1, 250, 1, 1, 0, 1);
        apply(0, 0, 0, 250);
        repeat (5) @(posedge CLK);
        #1 check("rst_pre_rd", 2, 150, 1, 1, 0, 0);
        @(negedge CLK);
        #1 RESET_N = 0; bus.RUN = 1;
        #1 check("rst_async", 0, 0, 0, 0, 0, 0);
        #1 RESET_N = 1;
        @(posedge CLK); #1 check("rst_restart", 1, 0, 1, 1, 0, 0);
        repeat (4) @(posedge CLK);
        #1 check("rst_ramp", 1, 100, 1, 1, 0, 0);

        // randomized run against the reference model
        @(negedge CLK);
        RESET_N = 0;
        bus.RUN = 0; bus.DIR_REQ = 0; bus.FAULT = 0; bus.TARGET = 12'd300;
        #1 model_reset();
        check_model("rand_reset");
        @(negedge CLK);
        RESET_N = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) bus.RUN = ~bus.RUN;
            if ($urandom_range(0, 59) == 0) bus.DIR_REQ = ~bus.DIR_REQ;
            if (bus.FAULT) begin
                if ($urandom_range(0, 3) == 0) bus.FAULT = 0;
            end else if ($urandom_range(0, 399) == 0) begin
                bus.FAULT = 1;
            end
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.TARGET = 12'd0;
                    1:       bus.TARGET = 12'd4095;
                    2:       bus.TARGET = 12'($urandom_range(0, 5) * 100);
                    default: bus.TARGET = 12'($urandom_range(0, 4095));
                endcase
            end
            @(posedge CLK);
            model_step(bus.RUN, bus.DIR_REQ, bus.FAULT, int'(bus.TARGET));
            #1 check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ac_motor_sequencer.md
# ac_motor_sequencer

Run/stop and direction sequencer for the AC motor PWM path: it drives the comparator's ENABLE/CW/CCW inputs and the amplitude LEVEL fed to the sine generator. It ramps amplitude toward a target at a programmable rate. On a stop or direction change it ramps to zero, coasts with the bridge off for a fixed time, and only then restarts, so the bridge is never reversed under load. A FAULT input forces an immediate latched shutdown.

## Interface
Parameters:
- level_bits, 12, width of TARGET/LEVEL (unsigned amplitude).
- ramp_div, 1000, clock cycles per ramp tick (≥1).
- level_step, 1, LEVEL change per tick (≥1, < 2^level_bits).
- coast_cycles, 5000, cycles spent in COAST with bridge off (≥1).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level request: 1 = motor on.
- DIR_REQ  in  1  requested direction: 0 = CW, 1 = CCW.
- TARGET  in  level_bits  requested amplitude, sampled on every tick.
- FAULT  in  1  level fault input, highest priority.
- ENABLE  out  1  comparator enable.
- CW  out  1  clockwise select.
- CCW  out  1  counter-clockwise select.
- LEVEL  out  level_bits  current amplitude to sine generator.
- AT_LEVEL  out  1  high in RUN when LEVEL == TARGET.
- STATE  out  3  IDLE=0, RUN=1, RAMP_DOWN=2, COAST=3, FAULT=4.

## Operation
- All outputs are registered. Reset values: STATE=IDLE, LEVEL=0, ENABLE=CW=CCW=AT_LEVEL=0, prescaler=0, coast counter=0.
- Prescaler: clears on every state transition. Otherwise it increments each cycle; at value ramp_div-1 it emits a tick and wraps to 0.
- IDLE: outputs are at reset values. RUN=1 with FAULT=0 → RUN; DIR_REQ is latched as dir, CW=!dir, CCW=dir, ENABLE=1.
- RUN: on each tick, LEVEL moves toward TARGET:
  - up: min(LEVEL+level_step, TARGET);
  - down: max(LEVEL-level_step, TARGET);
  - arithmetic is level_bits+1 wide; no wrap.
  - RUN=0 or DIR_REQ≠dir → RAMP_DOWN.
- RAMP_DOWN: ENABLE and CW/CCW are unchanged. On each tick, LEVEL = max(LEVEL-level_step, 0).
  - The tick that produces LEVEL=0 also moves to COAST.
  - If entered with LEVEL already 0, move to COAST on the next cycle.
  - RUN and DIR_REQ are ignored; the ramp always completes.
- COAST: ENABLE=CW=CCW=0, LEVEL=0. The counter loads coast_cycles on entry and decrements each cycle. The state lasts exactly coast_cycles cycles, then:
  - RUN=1 → RUN with a freshly latched dir;
  - RUN=0 → IDLE.
- FAULT: FAULT=1 in any state → FAULT on the next edge with LEVEL=0 and ENABLE=CW=CCW=AT_LEVEL=0.
  - The state holds until FAULT=0 and RUN=0 are both true in the same cycle, then → IDLE.
  - RUN must be deasserted to re-arm.
- Priority: reset > FAULT > stop/reversal > ramp tick.
- CW and CCW are never both 1.
- CW↔CCW never changes without passing through COAST.

## Timing
- Input-to-output latency is 1 cycle: an input sampled at edge k appears on the outputs after edge k.
- First LEVEL step occurs ramp_div edges after the state-entry edge. Later steps follow every ramp_div cycles.
- AT_LEVEL updates in the same cycle as LEVEL. A TARGET change alone affects AT_LEVEL on the next edge.
- Reversal from level L, in cycles: 1 + ceil(L/level_step)·ramp_div + coast_cycles until CW/CCW flips.
- Asynchronous reset mid-operation forces the reset values immediately. Operation resumes from IDLE on the first edge after release.

## Test plan
Benches use level_bits=12, ramp_div=4, level_step=100, coast_cycles=8.
- Start: RUN=1, DIR_REQ=0, TARGET=250 → next edge STATE=1, CW=1, ENABLE=1. LEVEL steps 100, 200, 250 at 4-cycle spacing, then AT_LEVEL=1.
- Reversal: in RUN at 250, DIR_REQ=1 → STATE=2, LEVEL 150, 50, 0. Then STATE=3 for exactly 8 cycles with CW=CCW=ENABLE=0. Then CCW=1, and LEVEL ramps 100, 200, 250.
- Stop: at 250, RUN=0 → ramp to 0, 8 coast cycles, then STATE=0 with all outputs 0. A DIR_REQ toggle during RAMP_DOWN has no effect.
- Saturation/tracking: TARGET=4095 → LEVEL …4000, 4095 with no wrap. Then TARGET=3900 → 3995, 3900, with AT_LEVEL=1 at 3900.
- Fault: FAULT=1 at LEVEL=200 → next edge STATE=4, LEVEL=0, outputs 0. Releasing FAULT with RUN=1 keeps STATE=4. RUN=0 → STATE=0.
- Reset: RESET_N pulsed low between edges during RAMP_DOWN → outputs 0 before the next edge. Holding RUN=1 after release → RUN entered, LEVEL ramps from 0.
